// File: rtl/touch_key_pkg.sv
// Shared types and constants for the touch-key decoder: FSM states, key code
// anchors and the white-key edges that carry a black key.
package touch_key_pkg;

  typedef enum logic [1:0] {IDLE, CAND, HELD} tk_state_t;

  localparam logic [3:0] KEY_NONE        = 4'd0;
  localparam logic [3:0] KEY_WHITE_FIRST = 4'd1;
  localparam logic [3:0] KEY_BLACK_FIRST = 4'd9;

  localparam int NUM_WHITE = 8;
  localparam int NUM_BLACK = 5;

  // Edge index j of each black key, lowest code first (C#, D#, F#, G#, A#).
  localparam logic [NUM_BLACK-1:0][3:0] BLACK_EDGE_IDX = {4'd6, 4'd5, 4'd4, 4'd2, 4'd1};

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/touch_key_region.sv
// Combinational x/y -> key-code map using constant edge comparisons only.
// The black-key band is decoded only when TOUCH_KEY_BLACK_EN is defined.
module touch_key_region
  import touch_key_pkg::*;
#(
  parameter logic [11:0] X_ORG   = 12'd160,
  parameter logic [11:0] KEY_W   = 12'd480,
  parameter logic [11:0] Y_SPLIT = 12'd2048
) (
  input  logic [11:0] i_x,
  input  logic [11:0] i_y,
  output logic [3:0]  o_code
);

  // Widened so that edges past 4095 (large overrides) still compare correctly.
  logic [15:0]          w_x;
  logic [NUM_WHITE-1:0] w_white;

  assign w_x = {4'd0, i_x};

  generate
    for (genvar gi = 0; gi < NUM_WHITE; gi++) begin : g_white
      localparam logic [15:0] LO = 16'(X_ORG) + 16'(gi) * 16'(KEY_W);
      localparam logic [15:0] HI = LO + 16'(KEY_W);
      assign w_white[gi] = (w_x >= LO) && (w_x < HI);
    end
  endgenerate

`ifdef TOUCH_KEY_BLACK_EN
  logic [NUM_BLACK-1:0] w_black;
  logic                 w_black_band;

  assign w_black_band = (i_y >= Y_SPLIT);

  generate
    for (genvar gi = 0; gi < NUM_BLACK; gi++) begin : g_black
      localparam logic [15:0] EJ = 16'(X_ORG) + 16'(BLACK_EDGE_IDX[gi]) * 16'(KEY_W);
      localparam logic [15:0] QW = 16'(KEY_W >> 2);
      // |x - EJ| < QW without a signed subtract
      assign w_black[gi] = ((w_x + QW) > EJ) && (w_x < (EJ + QW));
    end
  endgenerate
`else
  logic w_unused_y;
  assign w_unused_y = ^{i_y, Y_SPLIT};
`endif

  always_comb begin
    o_code = KEY_NONE;
    for (int i = 0; i < NUM_WHITE; i++) begin
      if (w_white[i]) o_code = KEY_WHITE_FIRST + 4'(i);
    end
`ifdef TOUCH_KEY_BLACK_EN
    for (int i = 0; i < NUM_BLACK; i++) begin
      if (w_black_band && w_black[i]) o_code = KEY_BLACK_FIRST + 4'(i);
    end
`endif
  end

endmodule

// File: rtl/touch_key_decoder.sv
// Debounced touchscreen -> piano key code with pen-up hold timer and key_new pulse.
// Optional black-key band: define TOUCH_KEY_BLACK_EN.
module touch_key_decoder
  import touch_key_pkg::*;
#(
  parameter int          DEBOUNCE_N  = 4,
  parameter logic [23:0] RELEASE_CYC = 24'd5_000_000,
  parameter logic [11:0] X_ORG       = 12'd160,
  parameter logic [11:0] KEY_W       = 12'd480,
  parameter logic [11:0] Y_SPLIT     = 12'd2048
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic        pen_down,
  input  logic [11:0] xaxis,
  input  logic [11:0] yaxis,
  output logic [3:0]  pianokey,
  output logic        key_valid,
  output logic        key_new
);

  localparam logic [3:0] DEB = 4'(DEBOUNCE_N);

  tk_state_t   r_state, r_state_next;
  logic [3:0]  r_cand, r_cand_next;
  logic [3:0]  r_cnt, r_cnt_next;
  logic [23:0] r_rel_tmr, r_rel_tmr_next;
  logic [3:0]  r_key, r_key_next;
  logic        r_key_new, r_key_new_next;

  logic [3:0]  w_code;
  logic        w_qual;
  logic [3:0]  w_cnt_inc;
  logic        w_deb_done;
  logic [23:0] w_rel_inc;

  touch_key_region #(
    .X_ORG   (X_ORG),
    .KEY_W   (KEY_W),
    .Y_SPLIT (Y_SPLIT)
  ) u_region (
    .i_x    (xaxis),
    .i_y    (yaxis),
    .o_code (w_code)
  );

  assign w_qual = sample_valid & pen_down;
  // A sample that does not extend the running candidate starts a fresh count of 1.
  assign w_cnt_inc  = ((w_code == r_cand) && (r_cnt != 4'd0)) ? sat_inc4(r_cnt) : 4'd1;
  assign w_deb_done = (w_cnt_inc >= DEB);
  assign w_rel_inc  = (r_rel_tmr == 24'hFF_FFFF) ? r_rel_tmr : r_rel_tmr + 24'd1;

  always_comb begin
    r_state_next   = r_state;
    r_cand_next    = r_cand;
    r_cnt_next     = r_cnt;
    r_rel_tmr_next = r_rel_tmr;
    r_key_next     = r_key;
    r_key_new_next = 1'b0;

    case (r_state)
      IDLE: begin
        r_rel_tmr_next = 24'd0;
        if (w_qual && (w_code != KEY_NONE)) begin
          r_cand_next = w_code;
          if (w_deb_done) begin
            r_state_next   = HELD;
            r_key_next     = w_code;
            r_key_new_next = 1'b1;
            r_cnt_next     = 4'd0;
          end else begin
            r_state_next = CAND;
            r_cnt_next   = w_cnt_inc;
          end
        end
      end

      CAND: begin
        if (!pen_down || (sample_valid && (w_code == KEY_NONE))) begin
          r_state_next = IDLE;
          r_cnt_next   = 4'd0;
        end else if (sample_valid) begin
          r_cand_next = w_code;
          if (w_deb_done) begin
            r_state_next   = HELD;
            r_key_next     = w_code;
            r_key_new_next = 1'b1;
            r_cnt_next     = 4'd0;
          end else begin
            r_cnt_next = w_cnt_inc;
          end
        end
      end

      HELD: begin
        r_rel_tmr_next = pen_down ? 24'd0 : w_rel_inc;
        if (!pen_down && (w_rel_inc >= RELEASE_CYC)) begin
          r_state_next   = IDLE;
          r_key_next     = KEY_NONE;
          r_rel_tmr_next = 24'd0;
          r_cnt_next     = 4'd0;
        end else if (w_qual) begin
          if (w_code == r_key) begin
            r_cnt_next = 4'd0;
          end else begin
            r_cand_next = w_code;
            if (w_deb_done) begin
              r_cnt_next = 4'd0;
              if (w_code == KEY_NONE) begin
                r_state_next = IDLE;
                r_key_next   = KEY_NONE;
              end else begin
                r_key_next     = w_code;
                r_key_new_next = 1'b1;
              end
            end else begin
              r_cnt_next = w_cnt_inc;
            end
          end
        end
      end

      default: begin
        r_state_next = IDLE;
        r_cnt_next   = 4'd0;
        r_key_next   = KEY_NONE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cand    <= KEY_NONE;
      r_cnt     <= 4'd0;
      r_rel_tmr <= 24'd0;
      r_key     <= KEY_NONE;
      r_key_new <= 1'b0;
    end else begin
      r_state   <= r_state_next;
      r_cand    <= r_cand_next;
      r_cnt     <= r_cnt_next;
      r_rel_tmr <= r_rel_tmr_next;
      r_key     <= r_key_next;
      r_key_new <= r_key_new_next;
    end
  end

  assign pianokey  = r_key;
  assign key_valid = (r_key != KEY_NONE);
  assign key_new   = r_key_new;

endmodule

// File: doc/touch_key_decoder.md
# touch_key_decoder

Converts raw touchscreen coordinate samples into a debounced 4-bit piano key code for the tone generator. It sits between the touch-controller ADC reader, which produces 12-bit x/y samples, and the piano-key filter/tone stage, which consumes the 4-bit key code. It maps x/y into white-key and black-key regions and requires several consecutive agreeing samples before accepting a key. It holds the key through short pen-up glitches and pulses on every accepted key change.

## Interface
- `DEBOUNCE_N`, default 4: consecutive identical decoded samples needed to accept a key (range 1–15).
- `RELEASE_CYC`, default 24'd5_000_000: consecutive pen-up cycles before a held key releases (100 ms at 50 MHz).
- `X_ORG`, default 12'd160: left edge of white key 1, in ADC counts.
- `KEY_W`, default 12'd480: white-key width, in ADC counts.
- `Y_SPLIT`, default 12'd2048: `yaxis >= Y_SPLIT` is the black-key band.
- `Clk` in 1: system clock; all logic rises on it.
- `rst` in 1: reset, asynchronous, active-high.
- `sample_valid` in 1: one-cycle strobe; `xaxis`/`yaxis` hold a new sample.
- `pen_down` in 1: level, 1 while the panel is touched.
- `xaxis` in 12: raw x sample.
- `yaxis` in 12: raw y sample.
- `pianokey` out 4: 0 = none; 1–8 = white keys; 9–13 = black keys C#, D#, F#, G#, A#.
- `key_valid` out 1: `pianokey != 0`.
- `key_new` out 1: one-cycle pulse when a nonzero key is accepted.

## Operation
- Region decode is combinational; there is no divider.
  - Edges are `E_k = X_ORG + k*KEY_W`, k = 0..8, all elaborated as constants.
  - White code `k+1` when `E_k <= x < E_{k+1}`.
  - Code 0 when `x < E_0` or `x >= E_8`.
  - Black code overrides white when `y >= Y_SPLIT` and `|x - E_j| < KEY_W/4`.
  - j = 1, 2, 4, 5, 6 map to codes 9, 10, 11, 12, 13 respectively.
- Only samples with `sample_valid & pen_down` are "qualified". Strobes with `pen_down` low are ignored.
- FSM states: IDLE, CAND, HELD. Registers: `cand[3:0]`, `cnt[3:0]`, `rel_tmr[23:0]`.
- **IDLE** (`pianokey = 0`)
  - A qualified sample with code ≠ 0 loads `cand = code`, `cnt = 1` and moves to CAND.
  - If `DEBOUNCE_N == 1`, it goes straight to HELD instead.
- **CAND**
  - Qualified sample with `code == cand`: `cnt++`. When `cnt` reaches `DEBOUNCE_N`, move to HELD, load `pianokey = cand`, pulse `key_new`.
  - Qualified sample with a different nonzero code: `cand = code`, `cnt = 1`.
  - Qualified sample with code 0, or `pen_down` low: return to IDLE.
- **HELD**
  - A shadow candidate tracks qualified samples whose code differs from `pianokey`, using the same `cand`/`cnt` debounce. A sample equal to `pianokey` clears `cnt`.
  - Debounced nonzero code: `pianokey` is replaced and `key_new` pulses (glissando).
  - Debounced code 0: go to IDLE, `pianokey = 0`, no pulse.
  - `rel_tmr` counts cycles with `pen_down` low and clears when `pen_down` is high.
  - When `rel_tmr` reaches `RELEASE_CYC`: go to IDLE, `pianokey = 0`.
- `rel_tmr` and `cnt` saturate and never wrap.

## Timing
- Reset: `pianokey = 0`, `key_valid = 0`, `key_new = 0`, state IDLE, all counters 0. Outputs clear asynchronously on `rst` assertion, including mid-HELD.
- `pianokey` and `key_new` are registered. They change on the first `Clk` edge after the sample that completes the debounce (latency 1 cycle).
- `key_valid` is derived combinationally from the `pianokey` register.
- Release takes effect on the edge where `rel_tmr` reaches `RELEASE_CYC`.
- Priority within one cycle, highest first: `rst`, then release timeout, then debounce completion.
- A sample that is both qualified and completing arrives with `pen_down` high, so the timer is already cleared in that cycle.

## Configuration
- `TOUCH_KEY_BLACK_EN` defined: the black-key band is decoded, and codes 9–13 are possible.
- `TOUCH_KEY_BLACK_EN` undefined: the `Y_SPLIT` comparison is removed, the decoder emits only 0–8, and `yaxis` is unused.

## Structure
- Package `touch_key_pkg` holds:
  - state enum `tk_state_t` (IDLE, CAND, HELD);
  - constants `KEY_NONE = 4'd0`, `KEY_WHITE_FIRST = 4'd1`, `KEY_BLACK_FIRST = 4'd9`;
  - black-boundary index list {1, 2, 4, 5, 6}.
- Sub-module `touch_key_region` holds the combinational x/y → code decode, including the `TOUCH_KEY_BLACK_EN` logic. The top level holds the FSM, debounce and release timer.

## Test plan
Defaults are used unless stated.
- **Basic accept:** 4 qualified samples x=700, y=1000 → `pianokey = 2` one cycle after the 4th strobe; `key_new` high for exactly 1 cycle; `key_valid = 1`.
- **Candidate restart:** 3 samples x=700, then 4 samples x=1200 → no output after the first 3; `pianokey = 3` after the 4th x=1200 sample; one `key_new` pulse in total.
- **Release timer:** key 2 held, `pen_down` low for 4_999_999 cycles then high → key stays 2. `pen_down` low for 5_000_000 cycles → `pianokey = 0`, no `key_new`.
- **Black key:** 4 samples x=650, y=3000 → `pianokey = 9` with `TOUCH_KEY_BLACK_EN`; `pianokey = 2` without it.
- **Out of area and glissando:**
  - 4 samples x=100 → stays 0.
  - Key 2 held, then 4 samples x=1200 → key 3 with a `key_new` pulse.
  - Then 4 samples x=4050 → 0 with no pulse.
- **Async reset:** `rst` asserted mid-HELD between clock edges → `pianokey = 0` and `key_valid = 0` immediately. After release, one sample x=700 does not produce a key.
